// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: RV64 load/store with sized, little-endian
// byte access, fixed access latency, illegal requests answered one edge after accept.
module dmem_responder #(
  parameter int DEPTH_WORDS = 512,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [IW-1:0] idx_q;
  logic [2:0]    off_q;
  logic [63:0]   wdata_q;
  logic          err_q;
  logic [63:0]   word_q;

  logic [63:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          misaligned;
  logic          out_of_range;
  logic          req_err;
  logic          access;

  logic          acc_we;
  logic [2:0]    acc_f3;
  logic [IW-1:0] acc_idx;
  logic [2:0]    acc_off;
  logic [63:0]   acc_wdata;
  logic [7:0]    be;
  logic [7:0]    be_sh;
  logic [63:0]   wd_sh;
  logic          mem_we;
  logic          mem_re;

  logic [63:0]   sh;
  logic [63:0]   ld;

  assign accept = req_valid_i && (state_q == IDLE);

  always_comb begin
    misaligned = 1'b0;
    case (req_funct3_i[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr_i[0];
      2'b10:   misaligned = |req_addr_i[1:0];
      default: misaligned = |req_addr_i[2:0];
    endcase
  end

  assign out_of_range = ({3'b000, req_addr_i[63:3]} >= 64'(DEPTH_WORDS));
  assign req_err = (req_funct3_i == 3'b111) || (req_we_i && req_funct3_i[2]) ||
                   misaligned || out_of_range;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_d = RESP;
          end else if (LATENCY == 1) begin
            state_d = RESP;
            access  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      idx_q   <= '0;
      off_q   <= 3'd0;
      wdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we_i;
        f3_q    <= req_funct3_i;
        idx_q   <= req_addr_i[IW+2:3];
        off_q   <= req_addr_i[2:0];
        wdata_q <= req_wdata_i;
        err_q   <= req_err;
      end
    end
  end

  // With LATENCY=1 the access happens on the accept edge, before the request is latched.
  assign acc_we    = (state_q == IDLE) ? req_we_i           : we_q;
  assign acc_f3    = (state_q == IDLE) ? req_funct3_i       : f3_q;
  assign acc_idx   = (state_q == IDLE) ? req_addr_i[IW+2:3] : idx_q;
  assign acc_off   = (state_q == IDLE) ? req_addr_i[2:0]    : off_q;
  assign acc_wdata = (state_q == IDLE) ? req_wdata_i        : wdata_q;

  always_comb begin
    be = 8'h00;
    case (acc_f3[1:0])
      2'b00:   be = 8'h01;
      2'b01:   be = 8'h03;
      2'b10:   be = 8'h0f;
      default: be = 8'hff;
    endcase
  end

  assign be_sh = be << acc_off;
  assign wd_sh = acc_wdata << {acc_off, 3'b000};

  // Gating with rst_i keeps a reset that overlaps the access edge from committing a store.
  assign mem_we = access && acc_we && !rst_i;
  assign mem_re = access && !acc_we && !rst_i;

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int k = 0; k < 8; k++) begin
        if (be_sh[k]) begin
          mem[acc_idx][8*k +: 8] <= wd_sh[8*k +: 8];
        end
      end
    end
    if (mem_re) begin
      word_q <= mem[acc_idx];
    end
  end

  assign sh = word_q >> {off_q, 3'b000};

  always_comb begin
    ld = 64'd0;
    case (f3_q)
      3'b000:  ld = {{56{sh[7]}},  sh[7:0]};
      3'b001:  ld = {{48{sh[15]}}, sh[15:0]};
      3'b010:  ld = {{32{sh[31]}}, sh[31:0]};
      3'b011:  ld = sh;
      3'b100:  ld = {56'd0, sh[7:0]};
      3'b101:  ld = {48'd0, sh[15:0]};
      3'b110:  ld = {32'd0, sh[31:0]};
      default: ld = 64'd0;
    endcase
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_err_o   = rsp_valid_o && err_q;
  assign rsp_rdata_o = (rsp_valid_o && !err_q && !we_q) ? ld : 64'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed bench for dmem_responder, checked cycle by cycle against a
// transaction-level byte-array model.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_f3 = 3'd0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_funct3_i(req_f3),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  task automatic chk(input string nm, input logic [66:0] act, input logic [66:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: byte-addressed memory plus one outstanding request.
  logic [7:0]  mm [DEPTH*8];
  bit          m_busy = 1'b0;
  int          m_n = 0;
  int          m_lat = 1;
  logic        m_we = 1'b0;
  logic        m_err = 1'b0;
  logic [2:0]  m_f3 = 3'd0;
  logic [63:0] m_addr = 64'd0;
  logic [63:0] m_wd = 64'd0;
  logic [63:0] m_rd = 64'd0;

  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [63:0] a);
    int sz;
    sz = 1 << f3[1:0];
    return (f3 == 3'd7) || (we && f3[2]) || ((a & 64'(sz - 1)) != 64'd0) ||
           ((a >> 3) >= 64'(DEPTH));
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] a);
    int sz;
    logic [63:0] v;
    sz = 1 << f3[1:0];
    v = 64'd0;
    for (int i = 0; i < sz; i++) v = v | (64'(mm[int'(a) + i]) << (8 * i));
    if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | (~64'd0 << (8 * sz));
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d);
    int sz;
    sz = 1 << f3[1:0];
    for (int i = 0; i < sz; i++) mm[int'(a) + i] = d[8*i +: 8];
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_n    = 0;
    end else if (m_busy) begin
      if (m_n >= m_lat) begin
        if (rsp_ready) m_busy = 1'b0;
      end else begin
        m_n++;
        if (m_n == m_lat && m_we && !m_err) model_store(m_f3, m_addr, m_wd);
      end
    end else if (req_valid) begin
      m_busy = 1'b1;
      m_we   = req_we;
      m_f3   = req_f3;
      m_addr = req_addr;
      m_wd   = req_wdata;
      m_err  = model_err(req_we, req_f3, req_addr);
      m_lat  = m_err ? 1 : LAT;
      m_rd   = (m_err || m_we) ? 64'd0 : model_load(m_f3, m_addr);
      m_n    = 1;
      if (m_n == m_lat && m_we && !m_err) model_store(m_f3, m_addr, m_wd);
    end
  end

  bit started = 1'b0;

  always @(negedge clk) begin
    if (started) begin : cmp
      logic v;
      v = m_busy && (m_n >= m_lat);
      chk("cycle", {req_ready, rsp_valid, rsp_err, rsp_rdata},
          {!m_busy, v, v && m_err, v ? m_rd : 64'd0});
    end
  end

  // Issues one request from posedge+1 and consumes its response after `hold` stalled cycles.
  task automatic xfer(input logic we, input logic [2:0] f3, input logic [63:0] a,
                      input logic [63:0] wd, input logic [63:0] er, input logic ee,
                      input int el, input int hold);
    int n;
    chk("ready_before", 67'(req_ready), 67'd1);
    req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_f3 = 3'($urandom);
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    n = 1;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 67'(n), 67'(el));
    chk("rdata", 67'(rsp_rdata), 67'(er));
    chk("err", 67'(rsp_err), 67'(ee));
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold", {req_ready, rsp_valid, rsp_err, rsp_rdata}, {1'b0, 1'b1, ee, er});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("idle_after", 67'({req_ready, rsp_valid}), 67'(2'b10));
  endtask

  initial begin
    #12;
    chk("reset_out", {req_ready, rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 1'b0, 64'd0});
    @(posedge clk); #1;
    rst = 1'b0;
    started = 1'b1;

    for (int w = 0; w < DEPTH; w++) xfer(1'b1, 3'd3, 64'(w * 8), {$urandom, $urandom}, 64'd0, 1'b0, LAT, 0);

    xfer(1'b1, 3'd3, 64'h10, 64'h8877665544332211, 64'd0, 1'b0, 2, 0);
    xfer(1'b0, 3'd3, 64'h10, 64'd0, 64'h8877665544332211, 1'b0, 2, 0);
    xfer(1'b0, 3'd0, 64'h17, 64'd0, 64'hFFFFFFFFFFFFFF88, 1'b0, 2, 0);
    xfer(1'b0, 3'd4, 64'h17, 64'd0, 64'h88, 1'b0, 2, 0);
    xfer(1'b0, 3'd1, 64'h16, 64'd0, 64'hFFFFFFFFFFFF8877, 1'b0, 2, 0);
    xfer(1'b0, 3'd6, 64'h14, 64'd0, 64'h88776655, 1'b0, 2, 0);
    xfer(1'b1, 3'd1, 64'h12, 64'hABCD, 64'd0, 1'b0, 2, 0);
    xfer(1'b0, 3'd3, 64'h10, 64'd0, 64'h88776655ABCD2211, 1'b0, 2, 0);
    xfer(1'b0, 3'd2, 64'h12, 64'd0, 64'd0, 1'b1, 1, 0);
    xfer(1'b1, 3'd4, 64'h10, 64'hFF, 64'd0, 1'b1, 1, 0);
    xfer(1'b0, 3'd3, 64'(8 * DEPTH), 64'd0, 64'd0, 1'b1, 1, 0);
    xfer(1'b0, 3'd3, 64'h10, 64'd0, 64'h88776655ABCD2211, 1'b0, 2, 5);

    xfer(1'b1, 3'd3, 64'h20, 64'h5, 64'd0, 1'b0, 2, 0);
    req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'd3; req_addr = 64'h20; req_wdata = 64'h1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk("reset_in_wait", {req_ready, rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 1'b0, 64'd0});
    @(posedge clk); #1;
    rst = 1'b0;
    xfer(1'b0, 3'd3, 64'h20, 64'd0, 64'h5, 1'b0, 2, 0);

    for (int c = 0; c < 4000; c++) begin : rnd
      int w;
      int off;
      logic [2:0] f3;
      @(posedge clk); #1;
      rst = ($urandom_range(0, 249) == 0);
      f3 = 3'($urandom);
      w = $urandom_range(0, DEPTH + 1);
      off = $urandom_range(0, 7);
      if ($urandom_range(0, 3) != 0) off = off & ~((1 << f3[1:0]) - 1);
      req_valid = ($urandom_range(0, 1) == 1);
      req_we    = ($urandom_range(0, 2) == 0);
      req_f3    = f3;
      req_addr  = 64'(w * 8 + off);
      if ($urandom_range(0, 31) == 0) req_addr[63] = 1'b1;
      req_wdata = {$urandom, $urandom};
      rsp_ready = ($urandom_range(0, 4) < 3);
    end

    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (LAT + 3) @(posedge clk);
    @(negedge clk); #1;
    started = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 512, number of 64-bit storage words.
REQ-002 Parameter LATENCY, default 2, number of clock edges from request accept to response valid for legal accesses; legal range 1..15.
REQ-003 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous and active-high.
REQ-005 req_valid_i  input  1  initiator presents a request.
REQ-006 req_ready_o  output  1  responder can accept a request.
REQ-007 req_we_i  input  1  1 = store, 0 = load.
REQ-008 req_funct3_i  input  3  RV64 access size/sign code.
REQ-009 req_addr_i  input  64  byte address.
REQ-010 req_wdata_i  input  64  store data, right-aligned.
REQ-011 rsp_valid_o  output  1  response present.
REQ-012 rsp_ready_i  input  1  initiator consumes the response.
REQ-013 rsp_rdata_o  output  64  load result, extended per funct3.
REQ-014 rsp_err_o  output  1  request was illegal; no access performed.

Function
REQ-015 FSM states: IDLE, WAIT, RESP; only one request is outstanding at a time.
REQ-016 req_ready_o SHALL be 1 only in IDLE; an accept is a rising edge with req_valid_i=1 and req_ready_o=1, which latches we, funct3, addr and wdata.
REQ-017 Request inputs outside an accept edge SHALL be ignored.
REQ-018 Decode: 000 B, 001 H, 010 W, 011 D signed; 100 BU, 101 HU, 110 WU unsigned; 111 illegal.
REQ-019 Error conditions: funct3=111; a store with funct3 >= 100; an address not a multiple of the access size; addr[63:3] >= DEPTH_WORDS.
REQ-020 Erroneous request: IDLE -> RESP on the accept edge; rsp_err_o=1; rsp_rdata_o=0; storage unchanged.
REQ-021 Legal request: IDLE -> WAIT on the accept edge; a down-counter loads LATENCY-1; LATENCY=1 goes directly to RESP.
REQ-022 In WAIT the counter decrements each edge; the edge on which it reads 1 moves to RESP and performs the access.
REQ-023 rsp_valid_o SHALL therefore first be 1 exactly LATENCY edges after the accept edge.
REQ-024 Storage is little-endian: byte k of word w is at address 8*w+k; word index is addr[63:3] and byte offset is addr[2:0].
REQ-025 Store: write only the size-selected bytes from the low bytes of wdata; leave other bytes unchanged; rsp_rdata_o=0.
REQ-026 Load: read the selected bytes, right-align them, then sign-extend (signed codes) or zero-extend (U codes) to 64 bits.
REQ-027 In RESP: rsp_valid_o, rsp_rdata_o and rsp_err_o are held stable until an edge with rsp_ready_i=1, which moves to IDLE.
REQ-028 No request may be accepted on the response-consume edge; the next accept is possible one edge later at the earliest.
REQ-029 Outside RESP: rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0.
REQ-030 rsp_ready_i asserted while rsp_valid_o=0 SHALL have no effect.
REQ-031 Storage SHALL be inferable as single-port synchronous RAM; its contents are undefined after power-up.

Reset
REQ-032 rst_i=1 immediately forces IDLE and counter 0, with req_ready_o=1, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0.
REQ-033 Reset does not clear storage contents.
REQ-034 Reset asserted before the access edge (REQ-022) SHALL cancel a pending store, leaving storage unchanged.
REQ-035 A response present when reset asserts SHALL be discarded.
REQ-036 The first accept is possible on the first rising edge after rst_i deasserts.

Verification
REQ-037 LATENCY=2: SD addr 0x10 data 0x8877665544332211, then LD 0x10 -> rsp_rdata_o=0x8877665544332211; each rsp_valid_o exactly 2 edges after its accept.
REQ-038 After REQ-037: LB 0x17 -> 0xFFFFFFFFFFFFFF88; LBU 0x17 -> 0x88; LH 0x16 -> 0xFFFFFFFFFFFF8877; LWU 0x14 -> 0x88776655.
REQ-039 After REQ-037: SH 0x12 data 0xABCD, then LD 0x10 -> 0x88776655ABCD2211.
REQ-040 Errors, each with err=1 and rdata=0 one edge after accept and storage unchanged: LW 0x12 (misaligned); SB funct3=100; LD with addr = 8*DEPTH_WORDS (out of range).
REQ-041 Backpressure: hold rsp_ready_i=0 for 5 cycles in RESP -> outputs stable and req_ready_o=0 throughout; assert rsp_ready_i -> IDLE on the next edge.
REQ-042 Assert rst_i during WAIT of an SD to 0x20 data 0x1 (0x20 previously held 0x5) -> outputs at reset values at once; a later LD 0x20 -> 0x5.
